// File: rtl/tpumac_pipe.sv
// Systolic-array MAC cell: forwards A/B one hop and accumulates signed A*B into Cout; optional clamp via `TPUMAC_SATURATE_EN.
// Latency: Aout/Bout 1 cycle; product reaches Cout after 1 (PIPE=0) or 2 (PIPE=1) cycles, one product per cycle.
// Backpressure: none; en may toggle every cycle, and a clr/WrEn edge squashes any product still in flight.
module tpumac_pipe #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int PIPE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       WrEn,
    input  logic                       clr,
    input  logic signed [BITS_AB-1:0]  Ain,
    input  logic signed [BITS_AB-1:0]  Bin,
    input  logic signed [BITS_C-1:0]   Cin,
    output logic signed [BITS_AB-1:0]  Aout,
    output logic signed [BITS_AB-1:0]  Bout,
    output logic signed [BITS_C-1:0]   Cout,
    output logic                       acc_vld,
    output logic                       ovf
);

    // Full-precision product width and the one-bit-wider sum used to spot overflow.
    localparam int PW = 2 * BITS_AB;
    localparam int SW = BITS_C + 1;

    logic [BITS_AB-1:0] a_q, a_d;
    logic [BITS_AB-1:0] b_q, b_d;
    logic [BITS_C-1:0]  c_q, c_d;
    logic               ovf_q, ovf_d;
    logic               acc_vld_q, acc_vld_d;

    logic signed [PW-1:0] prod_now;
    logic                 issue;
    logic                 add_vld;
    logic [PW-1:0]        add_val;
    logic [SW-1:0]        sum;
    logic                 sum_ovf;
    logic [BITS_C-1:0]    acc_res;

    // Product formed from the live operands; both casts sign-extend before multiplying.
    assign prod_now = PW'(Ain) * PW'(Bin);

    // A load or clear on this edge takes precedence, so no product is issued alongside it.
    assign issue = en & ~WrEn & ~clr;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [PW-1:0] prod_q, prod_d;
            logic          pv_q, pv_d;

            // Stage 1: capture an issued product; pv drops on any non-issuing edge, which also squashes on clr/WrEn.
            always_comb begin
                prod_d = prod_q;
                pv_d   = issue;
                if (issue) begin
                    prod_d = prod_now;
                end
            end

            // Stage 1 registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_q <= '0;
                    pv_q   <= 1'b0;
                end else begin
                    prod_q <= prod_d;
                    pv_q   <= pv_d;
                end
            end

            // Stage 2 drains regardless of en, but a clr/WrEn edge discards the held product.
            assign add_vld = pv_q & ~clr & ~WrEn;
            assign add_val = prod_q;
        end else begin : g_nopipe
            assign add_vld = issue;
            assign add_val = prod_now;
        end
    endgenerate

    // Sign-extended sum one bit wider than the accumulator; top two bits differing means overflow.
    assign sum     = {c_q[BITS_C-1], c_q} + {{(SW-PW){add_val[PW-1]}}, add_val};
    assign sum_ovf = sum[SW-1] ^ sum[SW-2];

`ifdef TPUMAC_SATURATE_EN
    localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    // Clamp toward the true sign (the extra sum bit) when the result does not fit.
    always_comb begin
        acc_res = sum[BITS_C-1:0];
        if (sum_ovf) begin
            acc_res = sum[SW-1] ? C_MIN : C_MAX;
        end
    end
`else
    // Two's-complement wrap: just drop the extra sum bit.
    assign acc_res = sum[BITS_C-1:0];
`endif

    // Next state for forwarding registers, accumulator, sticky flag and valid strobe (clr > WrEn > accumulate).
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        acc_vld_d = 1'b0;
        if (en) begin
            a_d = Ain;
            b_d = Bin;
        end
        if (clr) begin
            c_d   = '0;
            ovf_d = 1'b0;
        end else if (WrEn) begin
            c_d   = Cin;
            ovf_d = 1'b0;
        end else if (add_vld) begin
            c_d       = acc_res;
            ovf_d     = ovf_q | sum_ovf;
            acc_vld_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            acc_vld_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    assign Aout    = a_q;
    assign Bout    = b_q;
    assign Cout    = c_q;
    assign ovf     = ovf_q;
    assign acc_vld = acc_vld_q;

endmodule

// File: doc/tpumac_pipe.md
Name: tpumac_pipe

Overview:
Parametrised, optionally pipelined successor to the single-cycle TPU MAC cell, used as the processing element of the systolic array. It forwards A/B operands to neighbouring cells with a fixed 1-cycle latency and accumulates signed A*B products into Cout. Over the base cell it adds:
- an optional product register stage for timing closure
- synchronous clear
- squash of in-flight products on load or clear
- an accumulate-valid strobe
- a sticky overflow flag
- optional saturating arithmetic

Parameters:
BITS_AB, 8, signed width of A/B operands
BITS_C, 16, signed accumulator width; must satisfy BITS_C >= 2*BITS_AB
PIPE, 1, 0 = product added the same cycle it is formed; 1 = product registered, added one cycle later

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  operand enable: forward A/B and issue a product
WrEn  input  1  load Cout from Cin
clr  input  1  synchronous clear of accumulator, pipeline and flag
Ain  input  BITS_AB  signed operand A
Bin  input  BITS_AB  signed operand B
Cin  input  BITS_C  signed accumulator load value
Aout  output  BITS_AB  registered Ain
Bout  output  BITS_AB  registered Bin
Cout  output  BITS_C  signed accumulator
acc_vld  output  1  one-cycle pulse: Cout was updated by accumulation on the previous edge
ovf  output  1  sticky overflow flag

Behaviour:
- Reset: one clock, synchronous and active-high (rst). While rst=1, all outputs and internal state go to 0 on the next edge.
- Priority per edge: rst > clr > WrEn > accumulate.
- Aout/Bout:
  - capture Ain/Bin when en=1, otherwise hold
  - latency is always 1 regardless of PIPE
  - unaffected by clr and WrEn
- Product:
  - P = Ain*Bin, signed full-precision 2*BITS_AB bits
  - sign-extended to BITS_C+1 bits for the sum
- Issue: a product is issued on an edge where en=1 & WrEn=0 & clr=0.
- PIPE=0: on an issuing edge, Cout <= f(Cout + P). Latency 1.
- PIPE=1:
  - Stage 1 on an issuing edge: prod_q <= P and pv <= 1; on any other edge pv <= 0.
  - Stage 2 on an edge with pv=1 and no clr/WrEn: Cout <= f(Cout + prod_q).
  - Latency 2; throughput one product per cycle.
  - Stage 2 drains even when en=0.
- Squash:
  - A clr or WrEn edge discards any product in stage 1: pv <= 0 and no add.
  - That edge also does not issue a new product.
- WrEn: Cout <= Cin, ovf <= 0.
- clr: Cout <= 0, pv <= 0, ovf <= 0.
- clr and WrEn on the same edge: clr wins, Cout=0.
- Overflow:
  - computed on the (BITS_C+1)-bit sum when its top two bits differ
  - sets ovf on that edge; ovf stays 1 until rst, clr or WrEn
- f(): without SATURATE_EN, truncate to BITS_C bits (two's-complement wrap).
- acc_vld:
  - registered; 1 in the cycle after any edge where Cout was written by accumulation
  - 0 after load, clear or reset edges
- No back-pressure; en may toggle every cycle.

Optional Feature:
Macro TPUMAC_SATURATE_EN.
- Defined: on overflow, Cout clamps to +(2^(BITS_C-1)-1) on positive overflow or -2^(BITS_C-1) on negative overflow; ovf still sets.
- Undefined: wrap behaviour as above; no clamp logic is synthesised.

Test Plan:
Defaults throughout (BITS_AB=8, BITS_C=16, PIPE=1) except where noted.
1. Reset: rst=1 for 2 cycles with random inputs -> Aout=Bout=Cout=0, acc_vld=0, ovf=0. Inputs held with en=1 -> Aout tracks Ain one cycle later.
2. Accumulate:
   - Stimulus: WrEn Cin=100; then en with (A=3,B=4), then (A=-5,B=6).
   - Response: Cout=112 two edges after the first issue, then Cout=82. acc_vld high for exactly those 2 cycles.
   - PIPE=0 rerun: same values, one edge earlier each.
3. Positive overflow: WrEn Cin=32767, then en A=1,B=1.
   - Without macro: Cout=-32768, ovf=1.
   - With TPUMAC_SATURATE_EN: Cout=32767, ovf=1.
   - Either build: a subsequent WrEn Cin=0 -> ovf=0.
4. Negative overflow: WrEn Cin=-32768, then en A=-128,B=1.
   - Wrap build: Cout=32640.
   - Saturate build: Cout=-32768.
   - ovf=1 in both builds.
5. Squash: en A=10,B=10 at edge N, WrEn Cin=5 at edge N+1 -> Cout=5 and stays 5. Product 100 is never added; no acc_vld pulse.
6. clr mid-stream, then clr+WrEn together:
   - Stimulus: Cout=50 with pv=1 (A=2,B=2 in flight); assert clr -> Cout=0, ovf=0, next cycle Cout still 0.
   - Then clr=1, WrEn=1, Cin=7 on the same edge -> Cout=0.
